router_fsm_np: RTL and testbench

//  Parametrised packet-router control FSM; next generation of the 3-port router controller.

---
 rtl/router_fsm_np.sv | 91 +++++++++
 tb/tb_router_fsm_np.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/router_fsm_np.sv
// router_fsm_np: parametrised packet-router control FSM with registered destination and header-address check.
// Define ROUTER_WAIT_TIMEOUT_EN to drop a packet that waits WAIT_TIMEOUT cycles for a non-empty FIFO.
module router_fsm_np #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    din,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_rst,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic [ADDR_W-1:0]    dest_sel,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 laf_state,
    output logic                 rst_in_reg,
    output logic                 wr_en_reg,
    output logic                 busy,
    output logic                 addr_err,
    output logic                 wait_timeout
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
        LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
    } state_t;
    localparam int PW = 2 ** ADDR_W;
    if (NUM_PORTS < 2 || NUM_PORTS > 16 || PW < NUM_PORTS || WAIT_TIMEOUT < 1) begin : g_bad_params
        $error("router_fsm_np: invalid parameters");
    end
    state_t state, next;
    logic [PW-1:0] empty_pad, srst_pad;
    logic av, sel_empty, sel_srst, timeout;
    // Padding to the full address range lets din/dest_sel index without range issues.
    assign empty_pad = PW'(fifo_empty);
    assign srst_pad  = PW'(soft_rst);
    assign av        = pkt_valid && ({1'b0, din} < (ADDR_W+1)'(NUM_PORTS));
    assign sel_empty = empty_pad[dest_sel];
    assign sel_srst  = srst_pad[dest_sel];
`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (state == WAIT_TILL_EMPTY) ? cnt + CW'(1) : '0;
    assign timeout = state == WAIT_TILL_EMPTY && !sel_empty && cnt == CW'(WAIT_TIMEOUT - 1);
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        next = state;
        case (state)
            DECODE_ADDRESS:     next = av ? (empty_pad[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY) : DECODE_ADDRESS;
            LOAD_FIRST_DATA:    next = LOAD_DATA;
            LOAD_DATA:          next = fifo_full ? FIFO_FULL_STATE : (!pkt_valid ? LOAD_PARITY : LOAD_DATA);
            FIFO_FULL_STATE:    next = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    next = parity_done ? DECODE_ADDRESS : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
            LOAD_PARITY:        next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    next = sel_empty ? LOAD_FIRST_DATA : (timeout ? DECODE_ADDRESS : WAIT_TILL_EMPTY);
            default:            next = DECODE_ADDRESS;
        endcase
        if (state != DECODE_ADDRESS && sel_srst) next = DECODE_ADDRESS;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= DECODE_ADDRESS;
            dest_sel     <= '0;
            addr_err     <= 1'b0;
            wait_timeout <= 1'b0;
        end else begin
            state        <= next;
            if (state == DECODE_ADDRESS && av) dest_sel <= din;
            addr_err     <= state == DECODE_ADDRESS && pkt_valid && !av;
            wait_timeout <= timeout && !sel_srst;
        end
    assign detect_add = state == DECODE_ADDRESS;
    assign lfd_state  = state == LOAD_FIRST_DATA;
    assign ld_state   = state == LOAD_DATA;
    assign full_state = state == FIFO_FULL_STATE;
    assign laf_state  = state == LOAD_AFTER_FULL;
    assign rst_in_reg = state == CHECK_PARITY_ERROR;
    assign wr_en_reg  = state == LOAD_DATA || state == LOAD_AFTER_FULL || state == LOAD_PARITY;
    assign busy       = !(state == DECODE_ADDRESS || state == LOAD_DATA);
endmodule

// File: tb/tb_router_fsm_np.sv
// tb_router_fsm_np: table-driven checks of router_fsm_np with an expected-output queue.
module tb_router_fsm_np;
    // {detect_add, lfd, ld, full, laf, rst_in_reg, wr_en_reg, busy}
    localparam logic [7:0] S_DA  = 8'b1000_0000;
    localparam logic [7:0] S_LFD = 8'b0100_0001;
    localparam logic [7:0] S_LD  = 8'b0010_0010;
    localparam logic [7:0] S_FF  = 8'b0001_0001;
    localparam logic [7:0] S_LAF = 8'b0000_1011;
    localparam logic [7:0] S_LP  = 8'b0000_0011;
    localparam logic [7:0] S_CPE = 8'b0000_0101;
    localparam logic [7:0] S_WTE = 8'b0000_0001;
    typedef struct {
        logic pv; logic [1:0] din; logic full; logic [2:0] empty; logic [2:0] srst;
        logic pd; logic lpv; logic [7:0] so; logic [1:0] ds; logic ae; logic wt;
    } vec_t;
    typedef struct { logic [11:0] v; int id; } exp_t;
    logic clk = 0, rst = 1, pkt_valid = 0, fifo_full = 0, parity_done = 0, low_pkt_valid = 0;
    logic [1:0] din = '0;
    logic [2:0] fifo_empty = 3'b111, soft_rst = '0;
    logic [1:0] dest_sel;
    logic detect_add, lfd_state, ld_state, full_state, laf_state, rst_in_reg, wr_en_reg, busy, addr_err, wait_timeout;
    int errors = 0, checks = 0, vid = 0;
    exp_t exp_q[$];
    vec_t tbl[$];
    always #5 clk = ~clk;
    router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .soft_rst(soft_rst), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .dest_sel(dest_sel), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .full_state(full_state),
        .laf_state(laf_state), .rst_in_reg(rst_in_reg), .wr_en_reg(wr_en_reg), .busy(busy),
        .addr_err(addr_err), .wait_timeout(wait_timeout)
    );
    function automatic vec_t mk(logic pv, logic [1:0] d, logic f, logic [2:0] e, logic [2:0] s,
                                logic pd, logic lpv, logic [7:0] so, logic [1:0] ds, logic ae, logic wt);
        vec_t v;
        v.pv = pv; v.din = d; v.full = f; v.empty = e; v.srst = s; v.pd = pd; v.lpv = lpv;
        v.so = so; v.ds = ds; v.ae = ae; v.wt = wt;
        return v;
    endfunction
    function automatic logic [11:0] outs();
        return {detect_add, lfd_state, ld_state, full_state, laf_state, rst_in_reg, wr_en_reg, busy,
                dest_sel, addr_err, wait_timeout};
    endfunction
    task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got states=%b dest=%0d aerr=%b wto=%b, want states=%b dest=%0d aerr=%b wto=%b",
                     name, act[11:4], act[3:2], act[1], act[0], exp[11:4], exp[3:2], exp[1], exp[0]);
        end
    endtask
    task automatic step(vec_t v);
        @(negedge clk);
        pkt_valid = v.pv; din = v.din; fifo_full = v.full; fifo_empty = v.empty;
        soft_rst = v.srst; parity_done = v.pd; low_pkt_valid = v.lpv;
        exp_q.push_back('{{v.so, v.ds, v.ae, v.wt}, vid});
        vid++;
    endtask
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("vec%0d", e.id), outs(), e.v);
        end
    end
    initial begin
        #2 chk("reset", outs(), {S_DA, 2'd0, 1'b0, 1'b0});
        @(negedge clk) rst = 0;
        // normal packet to port 2
        tbl.push_back(mk(1, 2, 0, 7, 0, 0, 0, S_LFD, 2, 0, 0));
        repeat (4) tbl.push_back(mk(1, 2, 0, 7, 0, 0, 0, S_LD, 2, 0, 0));
        tbl.push_back(mk(0, 2, 0, 7, 0, 0, 0, S_LP, 2, 0, 0));
        tbl.push_back(mk(0, 2, 0, 7, 0, 0, 0, S_CPE, 2, 0, 0));
        tbl.push_back(mk(0, 2, 0, 7, 0, 0, 0, S_DA, 2, 0, 0));
        // full stall, low_pkt_valid, CPE re-entering full, parity_done priority
        tbl.push_back(mk(1, 0, 0, 7, 0, 0, 0, S_LFD, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7, 0, 0, 0, S_LD, 0, 0, 0));
        repeat (3) tbl.push_back(mk(1, 0, 1, 7, 0, 0, 0, S_FF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7, 0, 0, 1, S_LAF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7, 0, 0, 1, S_LP, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, S_CPE, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7, 0, 0, 0, S_FF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, S_LAF, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7, 0, 1, 1, S_DA, 0, 0, 0));
        // LAF falling back to LD
        tbl.push_back(mk(1, 1, 0, 7, 0, 0, 0, S_LFD, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 7, 0, 0, 0, S_LD, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 7, 0, 0, 0, S_FF, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 7, 0, 0, 0, S_LAF, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 7, 0, 0, 0, S_LD, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 7, 0, 0, 0, S_LP, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 7, 0, 0, 0, S_CPE, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 7, 0, 0, 0, S_DA, 1, 0, 0));
        // bad address
        tbl.push_back(mk(1, 3, 0, 7, 0, 0, 0, S_DA, 1, 1, 0));
        tbl.push_back(mk(1, 3, 0, 7, 0, 0, 0, S_DA, 1, 1, 0));
        tbl.push_back(mk(0, 3, 0, 7, 0, 0, 0, S_DA, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 7, 0, 0, 0, S_DA, 1, 0, 0));
        // wait and soft reset
        tbl.push_back(mk(1, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3'b101, 3'b001, 0, 0, S_WTE, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3'b101, 3'b010, 0, 0, S_DA, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7, 3'b111, 0, 0, S_DA, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2, 0, 0));
        tbl.push_back(mk(0, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2, 0, 0));
        tbl.push_back(mk(0, 2, 0, 7, 0, 0, 0, S_LFD, 2, 0, 0));
        tbl.push_back(mk(1, 2, 0, 7, 0, 0, 0, S_LD, 2, 0, 0));
        tbl.push_back(mk(1, 2, 0, 7, 3'b100, 0, 0, S_DA, 2, 0, 0));
        foreach (tbl[i]) step(tbl[i]);
`ifdef ROUTER_WAIT_TIMEOUT_EN
        step(mk(1, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1, 0, 0));
        repeat (7) step(mk(0, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1, 0, 0));
        step(mk(0, 1, 0, 3'b101, 0, 0, 0, S_DA, 1, 0, 1));
        step(mk(0, 1, 0, 3'b101, 0, 0, 0, S_DA, 1, 0, 0));
        // empty wins over timeout on the last count
        step(mk(1, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1, 0, 0));
        repeat (7) step(mk(0, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1, 0, 0));
        step(mk(0, 1, 0, 7, 0, 0, 0, S_LFD, 1, 0, 0));
        step(mk(0, 1, 0, 7, 3'b010, 0, 0, S_DA, 1, 0, 0));
`else
        step(mk(1, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1, 0, 0));
        repeat (12) step(mk(0, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1, 0, 0));
        step(mk(0, 1, 0, 3'b101, 3'b010, 0, 0, S_DA, 1, 0, 0));
`endif
        // asynchronous reset in the middle of a packet
        step(mk(1, 2, 0, 7, 0, 0, 0, S_LFD, 2, 0, 0));
        step(mk(1, 2, 0, 7, 0, 0, 0, S_LD, 2, 0, 0));
        @(negedge clk);
        #2;
        pkt_valid = 0; din = 0;
        rst = 1;
        #1 chk("async_rst", outs(), {S_DA, 2'd0, 1'b0, 1'b0});
        @(negedge clk) rst = 0;
        step(mk(0, 0, 0, 7, 0, 0, 0, S_DA, 0, 0, 0));
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
